mul_iterative_unit: RTL
=======================

# mul_iterative_unit

Multi-cycle 64-bit integer multiplier for the LEGv8 datapath (MUL, SMULH, UMULH). Its operands come from the register file read ports (BusA, BusB), and its result drives the register file write port (BusW/RW/RegWr). It sits between register read and write-back and stalls the rest of the datapath through Busy while it iterates. It uses a radix-2 shift-add algorithm on operand magnitudes, with a final sign-correction cycle.

## Interface
- WIDTH, 64, operand and result width; the product register is 2*WIDTH.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- Start  in  1  request to begin an operation. Sampled on a rising edge only in IDLE or DONE.
- Op  in  2  operation select:
  - 00 = MUL (low 64 bits of the product).
  - 01 = SMULH (high 64 bits, signed × signed).
  - 10 = UMULH (high 64 bits, unsigned × unsigned).
  - 11 = treated as UMULH.
- OpA  in  WIDTH  multiplicand (from BusA).
- OpB  in  WIDTH  multiplier (from BusB).
- DestIn  in  5  destination register number, captured with Start.
- Busy  out  1  high while state is CALC or FIXUP.
- Done  out  1  high for exactly one cycle, in state DONE.
- Result  out  WIDTH  selected product half. Held stable from entry to DONE until the next accepted Start.
- RW  out  5  captured DestIn. Held with Result.
- RegWr  out  1  equals Done, except forced to 0 when the captured DestIn == 31.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - Start=1 captures Op, DestIn, |OpA| and |OpB|.
  - The product register P[127:0] is loaded as {64'b0, |OpB|}.
  - Iteration counter cleared to 0; next state CALC.
  - Start=0: remain in IDLE.
- Magnitudes:
  - Taken (two's-complement negation of a negative operand) only when Op=01.
  - For MUL and UMULH the operands are used unsigned. MUL's low half is sign-independent.
  - |0x8000_0000_0000_0000| = 0x8000_0000_0000_0000 as an unsigned 64-bit value; no overflow.
- Negate flag: captured as OpA[63]^OpB[63] when Op=01, else 0.
- CALC, once per cycle:
  - If P[0]=1, form a 65-bit sum {carry, P[127:64]+|A|}.
  - Shift {carry, sum or P[127:64], P[63:0]} right by 1 into P.
  - Increment the counter. After the 64th iteration (counter reaches 63), next state FIXUP.
- FIXUP:
  - If negate=1, P ← two's complement of P over 128 bits.
  - Result ← P[63:0] for Op=00, else P[127:64].
  - Next state DONE.
- DONE:
  - Done=1 for one cycle; RegWr=1 unless RW==31.
  - Start=1 in DONE is accepted exactly as in IDLE (back-to-back operation; next state CALC).
  - Otherwise next state IDLE.
- Start in CALC or FIXUP is ignored, with no queuing; OpA, OpB, Op and DestIn changes during these states have no effect.
- Reset (asynchronous, any state, including mid-CALC):
  - State ← IDLE; P, counter and negate ← 0.
  - Outputs: Busy=0, Done=0, RegWr=0, Result=0, RW=0.
  - Any in-flight operation is discarded with no write pulse.
  - Reset deassertion is synchronised externally.

## Timing
- Start accepted at rising edge t0: Busy=1 from t0 through t65 (65 cycles).
- CALC iterations occur on edges t1..t64; FIXUP resolves at edge t65.
- Done, RegWr, Result and RW are valid from t65 to t66; this is one full clock cycle.
  - The register file writes on the falling edge inside that cycle, with Result stable for ≥ half a period.
- Latency from Start edge to Done rising: 65 cycles.
- Minimum issue interval with back-to-back Start in DONE: 66 cycles.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- MUL: OpA=3, OpB=5, DestIn=7, Start at t0 → Busy high t0–t65; Done, RegWr=1, RW=7, Result=15 during t65–t66; IDLE after t66.
- SMULH: OpA=0xFFFF_FFFF_FFFF_FFFF (−1), OpB=1 → Result=0xFFFF_FFFF_FFFF_FFFF. Same operands with Op=00 → Result=0xFFFF_FFFF_FFFF_FFFF.
- UMULH and MUL on all-ones: OpA=OpB=0xFFFF_FFFF_FFFF_FFFF:
  - Op=10 → Result=0xFFFF_FFFF_FFFF_FFFE.
  - Op=00 → Result=0x0000_0000_0000_0001.
  - SMULH of 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 → Result=0x4000_0000_0000_0000.
- Busy protocol: issue MUL 2×2. Pulse Start with different operands at t10 → ignored; Result=4, exactly one Done pulse. Then Start in the DONE cycle with 6×7 → accepted; Busy immediately, next Result=42 at t131.
- XZR destination: MUL 9×9 with DestIn=31 → Done=1, Result=81, RegWr=0.
- Reset mid-operation: Reset_L low at t30 (asynchronous, between edges) → Busy, Done, RegWr, Result and RW drop to 0 immediately. No Done after release; a fresh Start yields correct results.

Source files
------------

// File: rtl/mul_iterative_unit.sv
// mul_iterative_unit
// -------------------
// Multi-cycle 64-bit integer multiplier for the LEGv8 datapath
// (MUL, SMULH, UMULH). It uses radix-2 shift-add on the operand magnitudes,
// then a single sign-correction (FIXUP) cycle. Busy stalls the datapath
// while the unit iterates.
//
// Ports
//   Clk          in   system clock, rising-edge active
//   Reset_L      in   asynchronous active-low reset
//   Start        in   begin an operation (sampled only in IDLE or DONE)
//   Op[1:0]      in   00 MUL (low half), 01 SMULH, 10/11 UMULH (high half)
//   OpA[W-1:0]   in   multiplicand (BusA)
//   OpB[W-1:0]   in   multiplier   (BusB)
//   DestIn[4:0]  in   destination register, captured with Start
//   Busy         out  high in CALC and FIXUP
//   Done         out  one-cycle pulse in DONE
//   Result[W-1:0] out selected product half, held until the next FIXUP
//   RW[4:0]      out  destination register, held with Result
//   RegWr        out  Done, suppressed when RW == 31 (XZR)
//   dbg_state_o  out  current FSM state, for observation only
//
// Handshake: Start is a single-cycle request. It is accepted on a rising
// edge only when the FSM is in IDLE or DONE. Busy high means the request
// was taken and any further Start is dropped, with no queuing. Done/RegWr
// mark the one cycle in which Result/RW must be consumed. All outputs are
// decoded from registers, so no input reaches an output combinationally.

module mul_iterative_unit #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset_L,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [4:0]       DestIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       RW,
    output logic             RegWr,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [1:0]         op_q, op_d;
    logic [4:0]         dest_q, dest_d;
    logic [WIDTH-1:0]   amag_q, amag_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         rw_q, rw_d;

    // Operand magnitudes: only SMULH treats the operands as signed. The most
    // negative value maps to itself, which is the correct unsigned magnitude.
    logic             signed_req;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign signed_req = (Op == 2'b01);
    assign a_mag = (signed_req && OpA[WIDTH-1]) ? (~OpA + {{(WIDTH-1){1'b0}}, 1'b1}) : OpA;
    assign b_mag = (signed_req && OpB[WIDTH-1]) ? (~OpB + {{(WIDTH-1){1'b0}}, 1'b1}) : OpB;

    // One shift-add step: the carry out of the upper-half add becomes the
    // new MSB after the right shift.
    logic [WIDTH:0] upper_ext;
    logic [WIDTH:0] upper_sum;
    logic [WIDTH:0] upper_next;
    assign upper_ext  = {1'b0, p_q[2*WIDTH-1:WIDTH]};
    assign upper_sum  = upper_ext + {1'b0, amag_q};
    assign upper_next = p_q[0] ? upper_sum : upper_ext;

    // Sign correction over the full double-width product.
    logic [2*WIDTH-1:0] p_fix;
    assign p_fix = neg_q ? (~p_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_q;

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q  <= IDLE;
            p_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= 2'b00;
            dest_q   <= 5'd0;
            amag_q   <= '0;
            result_q <= '0;
            rw_q     <= 5'd0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            amag_q   <= amag_d;
            result_q <= result_d;
            rw_q     <= rw_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        op_d     = op_q;
        dest_d   = dest_q;
        amag_d   = amag_q;
        result_d = result_q;
        rw_d     = rw_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    op_d    = Op;
                    dest_d  = DestIn;
                    amag_d  = a_mag;
                    p_d     = {{WIDTH{1'b0}}, b_mag};
                    cnt_d   = '0;
                    neg_d   = signed_req & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                p_d   = {upper_next, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_ITER) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                p_d      = p_fix;
                result_d = (op_q == 2'b00) ? p_fix[WIDTH-1:0] : p_fix[2*WIDTH-1:WIDTH];
                // RW is published together with Result so both stay
                // stable through DONE even if a new Start is accepted.
                rw_d     = dest_q;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy        = (state_q == CALC) || (state_q == FIXUP);
    assign Done        = (state_q == DONE);
    assign RegWr       = (state_q == DONE) && (rw_q != 5'd31);
    assign Result      = result_q;
    assign RW          = rw_q;
    assign dbg_state_o = state_q;

endmodule
